// File: rtl/audio_sample_packet_assembler_pkg.sv
// rtl/audio_sample_packet_assembler_pkg.sv - shared constants and types for the audio sample packet assembler
package audio_sample_packet_assembler_pkg;

  localparam int CHANNEL_STATUS_LENGTH  = 192;
  localparam int MAX_SAMPLES_PER_PACKET = 4;
  localparam int SAMPLE_SLOT_WIDTH      = 24;

  // Left sits in the low half so a packed sample drops straight into a packet slot.
  typedef struct packed {
    logic [SAMPLE_SLOT_WIDTH-1:0] right;
    logic [SAMPLE_SLOT_WIDTH-1:0] left;
  } stereo_sample_t;

  typedef enum logic {
    IDLE,
    OFFER
  } asm_state_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - synchronous sample FIFO with pop-by-n and read-ahead of the oldest four entries
module audio_sample_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic [2:0]       pop_n,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic [WIDTH-1:0] head [4]
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;

  // Full is judged on the pre-pop count, so a push into a full FIFO is dropped even alongside a pop.
  assign full    = (count == CW'(DEPTH));
  assign push_ok = push && !full;

  // Sample storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; the caller never pops more than it holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_ptr + AW'(pop_n);
      count  <= count + CW'(push_ok) - CW'(pop_n);
    end
  end

  // Read-ahead window onto the four oldest entries.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      head[i] = mem[rd_ptr + AW'(i)];
    end
  end

endmodule

// File: rtl/audio_sample_packet_assembler.sv
// rtl/audio_sample_packet_assembler.sv - buffers stereo PCM strobes and offers up to four per audio sample packet
module audio_sample_packet_assembler
  import audio_sample_packet_assembler_pkg::*;
#(
  parameter int AUDIO_BIT_WIDTH       = 16,
  parameter int FIFO_DEPTH            = 8,
  parameter int CHANNEL_STATUS_LENGTH = 192
) (
  input  logic                       clk_pixel,
  input  logic                       reset,
  input  logic                       sample_valid,
  input  logic [AUDIO_BIT_WIDTH-1:0] sample_left,
  input  logic [AUDIO_BIT_WIDTH-1:0] sample_right,
  output logic                       packet_valid,
  input  logic                       packet_taken,
  output logic [7:0]                 frame_counter,
  output logic [7:0]                 valid_bit,
  output logic [7:0]                 user_data_bit,
  output logic [191:0]               audio_sample_word,
  output logic [3:0]                 audio_sample_word_present,
  output logic                       overflow
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int PAD = SAMPLE_SLOT_WIDTH - AUDIO_BIT_WIDTH;
  localparam int SW  = 2 * SAMPLE_SLOT_WIDTH;

  stereo_sample_t in_sample;
  logic [SW-1:0]  head [4];
  logic [CW-1:0]  fifo_count;
  logic           fifo_full;
  logic [2:0]     avail_n;
  logic [2:0]     pop_n;
  logic           capture;
  logic           take;

  asm_state_t     state;
  asm_state_t     next_state;
  logic [2:0]     snap_n;
  logic [191:0]   snap_slots;
  logic [3:0]     snap_present;
  logic [8:0]     fc_sum;
  logic [7:0]     fc_next;

  // Left-justify each PCM word into its 24-bit slot with zero LSBs.
  assign in_sample.left  = SAMPLE_SLOT_WIDTH'(sample_left)  << PAD;
  assign in_sample.right = SAMPLE_SLOT_WIDTH'(sample_right) << PAD;

  audio_sample_fifo #(
    .WIDTH (SW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_pixel),
    .reset     (reset),
    .push      (sample_valid),
    .push_data (in_sample),
    .pop_n     (pop_n),
    .count     (fifo_count),
    .full      (fifo_full),
    .head      (head)
  );

  assign avail_n = (fifo_count >= CW'(MAX_SAMPLES_PER_PACKET)) ? 3'd4 : 3'(fifo_count);

  assign fc_sum  = {1'b0, frame_counter} + 9'(snap_n);
  assign fc_next = (fc_sum >= 9'(CHANNEL_STATUS_LENGTH)) ? 8'(fc_sum - 9'(CHANNEL_STATUS_LENGTH))
                                                        : fc_sum[7:0];

  assign valid_bit     = 8'h00;
  assign user_data_bit = 8'h00;

  // State register.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state, snapshot/pop strobes and gated offer outputs.
  always_comb begin
    next_state                = state;
    capture                   = 1'b0;
    take                      = 1'b0;
    pop_n                     = 3'd0;
    packet_valid              = 1'b0;
    audio_sample_word         = '0;
    audio_sample_word_present = 4'b0000;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          capture    = 1'b1;
          next_state = OFFER;
        end
      end
      OFFER: begin
        packet_valid              = 1'b1;
        audio_sample_word         = snap_slots;
        audio_sample_word_present = snap_present;
        if (packet_taken) begin
          take       = 1'b1;
          pop_n      = snap_n;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Freeze the oldest n entries into the offer; unused slots are zeroed.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      snap_slots   <= '0;
      snap_present <= 4'b0000;
      snap_n       <= 3'd0;
    end else if (capture) begin
      for (int i = 0; i < MAX_SAMPLES_PER_PACKET; i++) begin
        snap_slots[SW*i +: SW] <= (3'(i) < avail_n) ? head[i] : '0;
        snap_present[i]        <= (3'(i) < avail_n);
      end
      snap_n <= avail_n;
    end
  end

  // Frame counter tracks slot 0 and advances by the number of samples consumed.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      frame_counter <= 8'd0;
    end else if (take) begin
      frame_counter <= fc_next;
    end
  end

  // One-cycle drop indication for a strobe that found the FIFO full.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      overflow <= 1'b0;
    end else begin
      overflow <= sample_valid && fifo_full;
    end
  end

endmodule

// File: tb/tb_audio_sample_packet_assembler.sv
// tb/tb_audio_sample_packet_assembler.sv - directed self-checking bench for the audio sample packet assembler
module tb_audio_sample_packet_assembler;

  logic         clk_pixel = 1'b0;
  logic         reset;
  logic         sample_valid;
  logic [15:0]  sample_left;
  logic [15:0]  sample_right;
  logic         packet_valid;
  logic         packet_taken;
  logic [7:0]   frame_counter;
  logic [7:0]   valid_bit;
  logic [7:0]   user_data_bit;
  logic [191:0] audio_sample_word;
  logic [3:0]   audio_sample_word_present;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  audio_sample_packet_assembler #(
    .AUDIO_BIT_WIDTH       (16),
    .FIFO_DEPTH            (8),
    .CHANNEL_STATUS_LENGTH (192)
  ) dut (
    .clk_pixel                 (clk_pixel),
    .reset                     (reset),
    .sample_valid              (sample_valid),
    .sample_left               (sample_left),
    .sample_right              (sample_right),
    .packet_valid              (packet_valid),
    .packet_taken              (packet_taken),
    .frame_counter             (frame_counter),
    .valid_bit                 (valid_bit),
    .user_data_bit             (user_data_bit),
    .audio_sample_word         (audio_sample_word),
    .audio_sample_word_present (audio_sample_word_present),
    .overflow                  (overflow)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string tag, input logic [191:0] observed, input logic [191:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic strobe(input logic [15:0] l, input logic [15:0] r);
    sample_valid = 1'b1;
    sample_left  = l;
    sample_right = r;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic take();
    packet_taken = 1'b1;
    tick();
    packet_taken = 1'b0;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    sample_valid = 1'b0;
    packet_taken = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_left  = '0;
    sample_right = '0;
    packet_taken = 1'b0;
    tick();
    tick();
    chk("rst_valid", packet_valid, 0);
    chk("rst_present", audio_sample_word_present, 0);
    chk("rst_word", audio_sample_word, 0);
    chk("rst_fc", frame_counter, 0);
    chk("rst_overflow", overflow, 0);
    chk("const_vbit", valid_bit, 0);
    chk("const_ubit", user_data_bit, 0);
    reset = 1'b0;
    tick();

    // Single strobe: offer appears two cycles after the strobe.
    strobe(16'h1234, 16'hABCD);
    chk("t1_valid_early", packet_valid, 0);
    tick();
    chk("t1_valid", packet_valid, 1);
    chk("t1_s0_left", audio_sample_word[23:0], 24'h123400);
    chk("t1_s0_right", audio_sample_word[47:24], 24'hABCD00);
    chk("t1_upper_zero", audio_sample_word[191:48], 0);
    chk("t1_present", audio_sample_word_present, 4'b0001);
    chk("t1_fc", frame_counter, 0);
    take();
    chk("t1_after_valid", packet_valid, 0);
    chk("t1_after_present", audio_sample_word_present, 0);
    chk("t1_after_fc", frame_counter, 1);
    tick();
    chk("t1_idle_empty", packet_valid, 0);

    // Six consecutive strobes: snapshot of one, then four, then one.
    do_reset();
    for (int i = 0; i < 6; i++) strobe(16'h0100 + 16'(i), 16'h0200 + 16'(i));
    chk("t2_o1_present", audio_sample_word_present, 4'b0001);
    chk("t2_o1_left", audio_sample_word[23:0], 24'h010000);
    chk("t2_o1_fc", frame_counter, 0);
    chk("t2_count6", dut.u_fifo.count, 6);
    take();
    chk("t2_gap_present", audio_sample_word_present, 0);
    tick();
    chk("t2_o2_present", audio_sample_word_present, 4'b1111);
    chk("t2_o2_fc", frame_counter, 1);
    chk("t2_o2_s0_left", audio_sample_word[23:0], 24'h010100);
    chk("t2_o2_s3_left", audio_sample_word[167:144], 24'h010400);
    chk("t2_o2_s3_right", audio_sample_word[191:168], 24'h020400);
    take();
    tick();
    chk("t2_o3_present", audio_sample_word_present, 4'b0001);
    chk("t2_o3_fc", frame_counter, 5);
    chk("t2_o3_left", audio_sample_word[23:0], 24'h010500);
    take();
    chk("t2_end_fc", frame_counter, 6);

    // Frame counter wrap: 190 single-sample packets, then n=1 at 190 and n=4 at 191.
    do_reset();
    for (int i = 0; i < 190; i++) begin
      strobe(16'(i), 16'(i));
      tick();
      take();
    end
    chk("t3_fc190", frame_counter, 190);
    for (int i = 0; i < 5; i++) strobe(16'h7000 + 16'(i), 16'h7100);
    chk("t3_o1_fc", frame_counter, 190);
    take();
    tick();
    chk("t3_o2_present", audio_sample_word_present, 4'b1111);
    chk("t3_o2_fc", frame_counter, 191);
    take();
    chk("t3_wrap_fc", frame_counter, 3);

    // Overflow on the ninth strobe; offer untouched.
    do_reset();
    for (int i = 0; i < 8; i++) strobe(16'h0A00 + 16'(i), 16'h0B00 + 16'(i));
    chk("t4_no_ovf", overflow, 0);
    chk("t4_count8", dut.u_fifo.count, 8);
    strobe(16'hDEAD, 16'hBEEF);
    chk("t4_ovf", overflow, 1);
    chk("t4_count_hold", dut.u_fifo.count, 8);
    chk("t4_present", audio_sample_word_present, 4'b0001);
    chk("t4_s0_left", audio_sample_word[23:0], 24'h0A0000);
    chk("t4_s0_right", audio_sample_word[47:24], 24'h0B0000);
    tick();
    chk("t4_ovf_pulse", overflow, 0);
    // Push on a full FIFO alongside a pop: push dropped, pop honoured.
    sample_valid = 1'b1;
    packet_taken = 1'b1;
    tick();
    sample_valid = 1'b0;
    packet_taken = 1'b0;
    chk("t4_fullpop_ovf", overflow, 1);
    chk("t4_fullpop_count", dut.u_fifo.count, 7);
    chk("t4_fullpop_fc", frame_counter, 1);

    // Take during IDLE is ignored; push and take together net to zero.
    do_reset();
    take();
    chk("t5_idle_fc", frame_counter, 0);
    chk("t5_idle_count", dut.u_fifo.count, 0);
    sample_left  = 16'h1111;
    sample_right = 16'h2222;
    sample_valid = 1'b1;
    packet_taken = 1'b1;
    tick();
    sample_valid = 1'b0;
    packet_taken = 1'b0;
    chk("t5_idle_push_count", dut.u_fifo.count, 1);
    chk("t5_idle_push_fc", frame_counter, 0);
    tick();
    chk("t5_offer_valid", packet_valid, 1);
    sample_left  = 16'h3333;
    sample_right = 16'h4444;
    sample_valid = 1'b1;
    packet_taken = 1'b1;
    tick();
    sample_valid = 1'b0;
    packet_taken = 1'b0;
    chk("t5_net_count", dut.u_fifo.count, 1);
    chk("t5_net_fc", frame_counter, 1);
    tick();
    chk("t5_next_left", audio_sample_word[23:0], 24'h333300);

    // Reset mid-offer discards the snapshot and queued samples.
    do_reset();
    strobe(16'h0001, 16'h0001);
    tick();
    take();
    for (int i = 0; i < 4; i++) strobe(16'h0C00 + 16'(i), 16'h0D00);
    chk("t6_pre_valid", packet_valid, 1);
    chk("t6_pre_fc", frame_counter, 1);
    do_reset();
    chk("t6_valid", packet_valid, 0);
    chk("t6_present", audio_sample_word_present, 0);
    chk("t6_fc", frame_counter, 0);
    chk("t6_count", dut.u_fifo.count, 0);
    strobe(16'h5555, 16'h6666);
    tick();
    chk("t6_new_valid", packet_valid, 1);
    chk("t6_new_fc", frame_counter, 0);
    chk("t6_new_left", audio_sample_word[23:0], 24'h555500);
    chk("t6_new_present", audio_sample_word_present, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_sample_packet_assembler.md
Name: audio_sample_packet_assembler

Overview:
- Upstream neighbour of the audio sample packet builder. Buffers stereo PCM samples arriving as single-cycle strobes in the pixel clock domain.
- Groups up to four buffered samples into a stable packet offer with a presence mask and an IEC 60958 frame counter.
- Releases the offer on a one-cycle take handshake from the data-island packet scheduler.
- Outputs connect directly to the packet builder's frame_counter, valid_bit, user_data_bit, audio_sample_word and audio_sample_word_present inputs.

Parameters:
- AUDIO_BIT_WIDTH, 16, width of incoming PCM samples. Legal range 16..24.
- FIFO_DEPTH, 8, stereo sample entries buffered. Power of two, ≥4.
- CHANNEL_STATUS_LENGTH, 192, frames per channel-status block; frame_counter wraps at this value.

Ports:
- clk_pixel  in  1  sole clock
- reset  in  1  synchronous, active-high
- sample_valid  in  1  one-cycle strobe; a stereo sample is presented this cycle
- sample_left  in  AUDIO_BIT_WIDTH  left channel PCM
- sample_right  in  AUDIO_BIT_WIDTH  right channel PCM
- packet_valid  out  1  offer stable and available
- packet_taken  in  1  scheduler consumed the offer this cycle
- frame_counter  out  8  frame index of sample slot 0, range 0..191
- valid_bit  out  8  per subframe; constant 0 (sample valid)
- user_data_bit  out  8  constant 0
- audio_sample_word  out  192  four slots × (left 24, right 24); slot i left at [48i+:24], right at [48i+24+:24]
- audio_sample_word_present  out  4  slot i holds a real sample
- overflow  out  1  one-cycle pulse when a sample is dropped

Behaviour:
- Interface: one clock (clk_pixel); reset is synchronous and active-high.
- Reset values:
  - packet_valid=0, audio_sample_word_present=0, audio_sample_word=0, frame_counter=0, overflow=0.
  - FIFO empty; state IDLE.
  - Applies mid-offer: the snapshot is discarded and the unsent samples are lost.
- Width rule: each sample is left-justified into 24 bits, LSBs zero-padded: word = {sample, (24-AUDIO_BIT_WIDTH)'b0}.
- FIFO:
  - Push on sample_valid when count<FIFO_DEPTH. A pushed entry is counted from the next cycle.
  - sample_valid while full: sample dropped, overflow pulses the next cycle, FIFO contents unchanged.
  - A push and a pop in the same cycle are both honoured. Full status is evaluated before the pop, so a push on a full FIFO is dropped even when a pop happens that cycle.
- State machine:
  - IDLE:
    - When count>0: n=min(count,4). Snapshot the n oldest entries into slots 0..n-1, with present mask bit i = (i<n).
    - Slots ≥n are driven 0. Go to OFFER with packet_valid=1 from the next cycle.
    - Earliest packet_valid is two cycles after the sample_valid strobe.
  - OFFER:
    - Outputs frozen; later pushes do not alter the snapshot.
    - On packet_taken: pop n entries and advance frame_counter by n modulo CHANNEL_STATUS_LENGTH, i.e. fc' = (fc+n≥192) ? fc+n−192 : fc+n.
    - Then return to IDLE: packet_valid=0 and present=0 for exactly one cycle.
  - packet_taken while in IDLE is ignored.
- frame_counter always refers to slot 0. Per-slot wrap (fc+i) is the downstream block's job.
- No backpressure toward the audio source; loss is reported only by overflow.

Decomposition:
- Shared package holds:
  - CHANNEL_STATUS_LENGTH = 192
  - MAX_SAMPLES_PER_PACKET = 4
  - SAMPLE_SLOT_WIDTH = 24
  - typedef for a stereo sample (two 24-bit words)
  - assembler state enum {IDLE, OFFER}
- One sub-module, audio_sample_fifo: synchronous FIFO parameterised by width and depth. Ports push, pop-by-n (0..4), count, and read-ahead access to the 4 oldest entries.

Test Plan:
- Reset, then one strobe with L=16'h1234, R=16'hABCD (AUDIO_BIT_WIDTH=16) -> packet_valid high 2 cycles later; slot0 = 24'h123400 / 24'hABCD00; present=4'b0001; frame_counter=0.
- Six strobes on consecutive cycles, scheduler idle -> first offer present=4'b0001 (snapshot taken before later samples land). After take: offer present=4'b1111, then present=4'b0001, with frame_counter 1 then 5.
- Drive 191 single-sample take cycles, then one offer with n=4 at fc=191 -> after take, frame_counter=3 (wrap).
- Fill 8 entries with packet_taken never asserted, then 9th strobe -> overflow single pulse; FIFO count stays 8; offer contents unchanged.
- packet_taken asserted during IDLE -> no pop, frame_counter unchanged. Push and take on the same cycle -> count net unchanged for n=1.
- Reset asserted while in OFFER with 3 samples queued -> next cycle packet_valid=0, present=0, frame_counter=0; new strobe yields fresh offer at fc=0.
